// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: icache (read-only) and dcache (read/write) share one
// memory port, one transaction in flight, dcache favoured with bounded icache starvation.
module mem_arbiter #(
  parameter int STARVE_MAX = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  // icache
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic [7:0]  i_len,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  // dcache
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [7:0]  d_len,
  output logic        d_gnt,
  input  logic        d_wvalid,
  input  logic [31:0] d_wdata,
  output logic        d_wready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  output logic        d_bdone,
  // memory
  output logic        m_avalid,
  output logic [31:0] m_addr,
  output logic        m_we,
  output logic [7:0]  m_len,
  input  logic        m_aready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  input  logic        m_rlast,
  output logic        m_wvalid,
  output logic [31:0] m_wdata,
  output logic        m_wlast,
  input  logic        m_wready,
  input  logic        m_bvalid
);

  localparam int NREQ  = 2;
  localparam int OWN_D = 0;
  localparam int OWN_I = 1;
  localparam int SW    = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    RDATA = 3'd2,
    WDATA = 3'd3,
    WRESP = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic          owner_reg, owner_next;   // 1 = icache, 0 = dcache
  logic [31:0]   addr_reg, addr_next;
  logic [7:0]    len_reg, len_next;
  logic          we_reg, we_next;
  logic [7:0]    beat_reg, beat_next;
  logic [SW-1:0] starve_reg, starve_next;

  logic            pick_i;
  logic            rd_route;
  logic [NREQ-1:0] gnt_vec;
  logic [NREQ-1:0] rvalid_vec;
  logic [NREQ-1:0] rlast_vec;
  logic [31:0]     rdata_vec [NREQ];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      owner_reg  <= 1'b0;
      addr_reg   <= '0;
      len_reg    <= '0;
      we_reg     <= 1'b0;
      beat_reg   <= '0;
      starve_reg <= '0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      addr_reg   <= addr_next;
      len_reg    <= len_next;
      we_reg     <= we_next;
      beat_reg   <= beat_next;
      starve_reg <= starve_next;
    end
  end

  // While rst_n is low every strobe stays quiet, so an abandoned burst emits nothing.
  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    addr_next   = addr_reg;
    len_next    = len_reg;
    we_next     = we_reg;
    beat_next   = beat_reg;
    starve_next = starve_reg;
    pick_i      = 1'b0;
    gnt_vec     = '0;
    rd_route    = 1'b0;
    m_avalid    = 1'b0;
    m_wvalid    = 1'b0;
    m_wdata     = '0;
    m_wlast     = 1'b0;
    d_wready    = 1'b0;
    d_bdone     = 1'b0;
    if (rst_n) begin
      case (state_reg)
        IDLE: begin
          if (i_req || d_req) begin
            pick_i     = i_req && (!d_req || (starve_reg == STARVE_LIM));
            owner_next = pick_i;
            addr_next  = pick_i ? i_addr : d_addr;
            len_next   = pick_i ? i_len : d_len;
            we_next    = !pick_i && d_we;
            state_next = ADDR;
          end
        end
        ADDR: begin
          m_avalid = 1'b1;
          if (m_aready) begin
            if (owner_reg) begin
              gnt_vec[OWN_I] = 1'b1;
              starve_next    = '0;
            end else begin
              gnt_vec[OWN_D] = 1'b1;
              if (i_req && (starve_reg != STARVE_LIM)) starve_next = starve_reg + 1'b1;
            end
            if (we_reg) begin
              beat_next  = len_reg;
              state_next = WDATA;
            end else begin
              state_next = RDATA;
            end
          end
        end
        RDATA: begin
          rd_route = 1'b1;
          if (m_rvalid && m_rlast) state_next = IDLE;
        end
        WDATA: begin
          m_wvalid = d_wvalid;
          m_wdata  = d_wdata;
          d_wready = m_wready;
          m_wlast  = (beat_reg == 8'd0);
          if (d_wvalid && m_wready) begin
            if (beat_reg == 8'd0) state_next = WRESP;
            else                  beat_next  = beat_reg - 8'd1;
          end
        end
        WRESP: begin
          if (m_bvalid) begin
            d_bdone    = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Read return goes only to the requester that owns the current burst.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_route
    logic sel;
    assign sel            = rd_route && (int'(owner_reg) == gi);
    assign rvalid_vec[gi] = sel && m_rvalid;
    assign rlast_vec[gi]  = sel && m_rvalid && m_rlast;
    assign rdata_vec[gi]  = sel ? m_rdata : '0;
  end

  assign i_gnt    = gnt_vec[OWN_I];
  assign d_gnt    = gnt_vec[OWN_D];
  assign i_rvalid = rvalid_vec[OWN_I];
  assign i_rlast  = rlast_vec[OWN_I];
  assign i_rdata  = rdata_vec[OWN_I];
  assign d_rvalid = rvalid_vec[OWN_D];
  assign d_rlast  = rlast_vec[OWN_D];
  assign d_rdata  = rdata_vec[OWN_D];

  assign m_addr = rst_n ? addr_reg : '0;
  assign m_len  = rst_n ? len_reg : '0;
  assign m_we   = rst_n && we_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table for reads/reset/stray beats,
// plus hand sequences for starvation ordering and a back-pressured write.
module tb_mem_arbiter;

  localparam logic [31:0] IA = 32'h1C00_0000;
  localparam logic [31:0] DA = 32'h2000_0040;
  localparam logic [31:0] WA = 32'h3000_0100;
  localparam int NV = 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0;
  logic [7:0]  i_len = '0, d_len = '0;
  logic        d_wvalid = 1'b0;
  logic [31:0] d_wdata = '0;
  logic        m_aready = 1'b0, m_rvalid = 1'b0, m_rlast = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        m_wready = 1'b0, m_bvalid = 1'b0;
  logic        i_gnt, i_rvalid, i_rlast, d_gnt, d_wready, d_rvalid, d_rlast, d_bdone;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        m_avalid, m_we, m_wvalid, m_wlast;
  logic [7:0]  m_len;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.STARVE_MAX(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_len(i_len), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rlast(i_rlast),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_len(d_len), .d_gnt(d_gnt),
    .d_wvalid(d_wvalid), .d_wdata(d_wdata), .d_wready(d_wready),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_bdone(d_bdone),
    .m_avalid(m_avalid), .m_addr(m_addr), .m_we(m_we), .m_len(m_len), .m_aready(m_aready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rlast(m_rlast),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wlast(m_wlast), .m_wready(m_wready),
    .m_bvalid(m_bvalid)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst_n, i_req, d_req, m_aready, m_rvalid, m_rlast;
    logic [31:0] m_rdata;
    logic        e_avalid;
    logic [31:0] e_addr;
    logic        e_i_gnt, e_d_gnt, e_i_rvalid, e_i_rlast, e_d_rvalid, e_d_rlast;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t v(input logic rs, ir, dr, ar, rv, rl, input logic [31:0] rd,
                             input logic ea, input logic [31:0] eaddr,
                             input logic eig, edg, eirv, eirl, edrv, edrl);
    vec_t r;
    r.rst_n = rs; r.i_req = ir; r.d_req = dr; r.m_aready = ar;
    r.m_rvalid = rv; r.m_rlast = rl; r.m_rdata = rd;
    r.e_avalid = ea; r.e_addr = eaddr;
    r.e_i_gnt = eig; r.e_d_gnt = edg; r.e_i_rvalid = eirv; r.e_i_rlast = eirl;
    r.e_d_rvalid = edrv; r.e_d_rlast = edrl;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    i_req = 0; d_req = 0; d_we = 0; d_wvalid = 0; d_wdata = '0;
    m_aready = 0; m_rvalid = 0; m_rlast = 0; m_rdata = '0; m_wready = 0; m_bvalid = 0;
  endtask

  logic got_i [6];
  logic exp_i [6];
  logic wr_pat [4];
  logic wl_pat [4];
  int   n_gnt;
  int   n_acc;

  initial begin
    // rows: rst,ireq,dreq,aready,rvalid,rlast,rdata | avalid,addr,ig,dg,irv,irl,drv,drl
    vecs[0]  = v(0,0,0,0,0,0,32'h0,    0,32'h0,0,0,0,0,0,0);
    vecs[1]  = v(0,1,1,1,1,1,32'hFFFF, 0,32'h0,0,0,0,0,0,0);  // inputs ignored in reset
    vecs[2]  = v(1,0,0,0,1,1,32'hDEAD, 0,32'h0,0,0,0,0,0,0);  // stray beat in IDLE
    vecs[3]  = v(1,0,0,0,0,0,32'h0,    0,32'h0,0,0,0,0,0,0);
    vecs[4]  = v(1,1,0,0,0,0,32'h0,    0,32'h0,0,0,0,0,0,0);
    vecs[5]  = v(1,1,0,1,0,0,32'h0,    1,IA,   1,0,0,0,0,0);
    vecs[6]  = v(1,0,0,0,1,0,32'hA0,   0,32'h0,0,0,1,0,0,0);
    vecs[7]  = v(1,0,0,0,1,0,32'hA1,   0,32'h0,0,0,1,0,0,0);
    vecs[8]  = v(1,0,0,0,1,0,32'hA2,   0,32'h0,0,0,1,0,0,0);
    vecs[9]  = v(1,0,0,0,1,1,32'hA3,   0,32'h0,0,0,1,1,0,0);
    vecs[10] = v(1,0,0,0,0,0,32'h0,    0,32'h0,0,0,0,0,0,0);
    vecs[11] = v(1,1,1,0,0,0,32'h0,    0,32'h0,0,0,0,0,0,0);  // both pending: dcache wins
    vecs[12] = v(1,1,1,1,0,0,32'h0,    1,DA,   0,1,0,0,0,0);
    vecs[13] = v(1,1,0,0,1,1,32'hB0,   0,32'h0,0,0,0,0,1,1);
    vecs[14] = v(1,1,0,0,0,0,32'h0,    0,32'h0,0,0,0,0,0,0);
    vecs[15] = v(1,1,0,0,0,0,32'h0,    1,IA,   0,0,0,0,0,0);  // 2 cycles after d rlast
    vecs[16] = v(1,1,0,1,0,0,32'h0,    1,IA,   1,0,0,0,0,0);
    vecs[17] = v(1,0,0,0,1,1,32'hC0,   0,32'h0,0,0,1,1,0,0);
    vecs[18] = v(1,0,0,0,0,0,32'h0,    0,32'h0,0,0,0,0,0,0);
    vecs[19] = v(1,1,0,0,0,0,32'h0,    0,32'h0,0,0,0,0,0,0);
    vecs[20] = v(1,1,0,1,0,0,32'h0,    1,IA,   1,0,0,0,0,0);
    vecs[21] = v(1,0,0,0,1,0,32'hD0,   0,32'h0,0,0,1,0,0,0);
    vecs[22] = v(1,0,0,0,1,0,32'hD1,   0,32'h0,0,0,1,0,0,0);
    vecs[23] = v(0,0,0,0,1,0,32'hD2,   0,32'h0,0,0,0,0,0,0);  // reset mid-burst
    vecs[24] = v(1,0,0,0,1,1,32'hD3,   0,32'h0,0,0,0,0,0,0);  // no rlast after reset
    vecs[25] = v(1,1,0,0,0,0,32'h0,    0,32'h0,0,0,0,0,0,0);
    vecs[26] = v(1,1,0,1,0,0,32'h0,    1,IA,   1,0,0,0,0,0);
    vecs[27] = v(1,0,0,0,1,0,32'hE0,   0,32'h0,0,0,1,0,0,0);
    vecs[28] = v(1,0,0,0,1,1,32'hE1,   0,32'h0,0,0,1,1,0,0);
    vecs[29] = v(1,0,0,0,0,0,32'h0,    0,32'h0,0,0,0,0,0,0);

    i_addr = IA; i_len = 8'd3; d_addr = DA; d_len = 8'd0; d_we = 1'b0;
    for (int k = 0; k < NV; k++) begin
      @(posedge clk); #1;
      rst_n = vecs[k].rst_n; i_req = vecs[k].i_req; d_req = vecs[k].d_req;
      m_aready = vecs[k].m_aready; m_rvalid = vecs[k].m_rvalid;
      m_rlast = vecs[k].m_rlast; m_rdata = vecs[k].m_rdata;
      @(negedge clk);
      chk($sformatf("row%0d m_avalid", k), 32'(m_avalid), 32'(vecs[k].e_avalid));
      chk($sformatf("row%0d i_gnt", k), 32'(i_gnt), 32'(vecs[k].e_i_gnt));
      chk($sformatf("row%0d d_gnt", k), 32'(d_gnt), 32'(vecs[k].e_d_gnt));
      chk($sformatf("row%0d i_rvalid", k), 32'(i_rvalid), 32'(vecs[k].e_i_rvalid));
      chk($sformatf("row%0d i_rlast", k), 32'(i_rlast), 32'(vecs[k].e_i_rlast));
      chk($sformatf("row%0d d_rvalid", k), 32'(d_rvalid), 32'(vecs[k].e_d_rvalid));
      chk($sformatf("row%0d d_rlast", k), 32'(d_rlast), 32'(vecs[k].e_d_rlast));
      chk($sformatf("row%0d wvalid/wlast/bdone", k),
          32'({m_wvalid, m_wlast, d_bdone}), 32'h0);
      if (vecs[k].e_avalid || !vecs[k].rst_n) begin
        chk($sformatf("row%0d m_addr", k), m_addr, vecs[k].e_addr);
        chk($sformatf("row%0d m_we", k), 32'(m_we), 32'h0);
      end
      if (vecs[k].e_i_rvalid) chk($sformatf("row%0d i_rdata", k), i_rdata, vecs[k].m_rdata);
      if (vecs[k].e_d_rvalid) chk($sformatf("row%0d d_rdata", k), d_rdata, vecs[k].m_rdata);
      $display("row %0d: avalid=%0b ignt=%0b dgnt=%0b irv=%0b irl=%0b drv=%0b",
               k, m_avalid, i_gnt, d_gnt, i_rvalid, i_rlast, d_rvalid);
    end

    // Starvation: both requesters held, single-beat reads, expect d,d,i,d,d,i.
    exp_i[0] = 0; exp_i[1] = 0; exp_i[2] = 1; exp_i[3] = 0; exp_i[4] = 0; exp_i[5] = 1;
    @(posedge clk); #1;
    i_len = 8'd0; d_len = 8'd0; d_we = 0;
    i_req = 1; d_req = 1; m_aready = 1; m_rvalid = 1; m_rlast = 1; m_rdata = 32'h55;
    n_gnt = 0;
    for (int c = 0; c < 60 && n_gnt < 6; c++) begin
      @(negedge clk);
      if (i_gnt || d_gnt) begin
        got_i[n_gnt] = i_gnt;
        $display("starve grant %0d: %s", n_gnt, i_gnt ? "icache" : "dcache");
        n_gnt++;
      end
      if (n_gnt < 6) begin
        @(posedge clk); #1;
      end
    end
    chk("starve grant count", 32'(n_gnt), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < n_gnt) chk($sformatf("starve grant %0d is_icache", k), 32'(got_i[k]), 32'(exp_i[k]));
    end
    @(posedge clk); #1;
    i_req = 0; d_req = 0;                    // final icache burst finishes this cycle
    @(negedge clk);
    @(posedge clk); #1;
    clear_inputs();
    m_bvalid = 1;                            // stray write response in IDLE
    @(negedge clk);
    chk("idle after starve m_avalid", 32'(m_avalid), 32'h0);
    chk("stray bvalid d_bdone", 32'(d_bdone), 32'h0);

    // Back-pressured write, len 1.
    @(posedge clk); #1;
    clear_inputs();
    d_req = 1; d_we = 1; d_addr = WA; d_len = 8'd1;
    @(negedge clk);
    chk("wr idle m_avalid", 32'(m_avalid), 32'h0);
    @(posedge clk); #1;
    m_aready = 1;
    @(negedge clk);
    chk("wr addr m_avalid", 32'(m_avalid), 32'h1);
    chk("wr addr m_addr", m_addr, WA);
    chk("wr addr m_we", 32'(m_we), 32'h1);
    chk("wr addr m_len", 32'(m_len), 32'h1);
    chk("wr addr d_gnt", 32'(d_gnt), 32'h1);
    $display("write addr: avalid=%0b addr=0x%0h we=%0b dgnt=%0b", m_avalid, m_addr, m_we, d_gnt);
    wr_pat[0] = 0; wr_pat[1] = 1; wr_pat[2] = 0; wr_pat[3] = 1;
    wl_pat[0] = 0; wl_pat[1] = 0; wl_pat[2] = 1; wl_pat[3] = 1;
    n_acc = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      d_req = 0; m_aready = 0;
      d_wvalid = 1; d_wdata = 32'hC0DE_0000 + 32'(n_acc); m_wready = wr_pat[k];
      @(negedge clk);
      chk($sformatf("wbeat%0d m_wvalid", k), 32'(m_wvalid), 32'h1);
      chk($sformatf("wbeat%0d d_wready", k), 32'(d_wready), 32'(wr_pat[k]));
      chk($sformatf("wbeat%0d m_wlast", k), 32'(m_wlast), 32'(wl_pat[k]));
      chk($sformatf("wbeat%0d m_wdata", k), m_wdata, 32'hC0DE_0000 + 32'(n_acc));
      if (m_wvalid && m_wready) n_acc++;
      $display("write beat %0d: wready=%0b wlast=%0b wdata=0x%0h", k, m_wready, m_wlast, m_wdata);
    end
    chk("write beats accepted", 32'(n_acc), 32'd2);
    @(posedge clk); #1;
    d_wvalid = 0; m_wready = 0; m_bvalid = 0;
    @(negedge clk);
    chk("wresp m_wvalid", 32'(m_wvalid), 32'h0);
    chk("wresp wait d_bdone", 32'(d_bdone), 32'h0);
    @(posedge clk); #1;
    m_bvalid = 1;
    @(negedge clk);
    chk("wresp d_bdone", 32'(d_bdone), 32'h1);
    $display("write resp: bvalid=%0b bdone=%0b", m_bvalid, d_bdone);
    @(posedge clk); #1;
    m_bvalid = 0;
    @(negedge clk);
    chk("post write d_bdone", 32'(d_bdone), 32'h0);
    chk("post write m_avalid", 32'(m_avalid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
